elevator_dispatcher: RTL and testbench

Per-car request scheduler that drives one elevator car's command inputs (target_floor, move_enable) and consumes its status outputs (current_floor, door_open, elevator_busy).
- Latches floor calls into a pending set.
- Selects the next target with SCAN (collective) ordering.
- Hands the target to the car and tracks each trip to completion.
- Sits between the call-button logic and the car FSM; one instance per car in the dual-car controller.

---
 rtl/elevator_pkg.sv | 31 +++
 rtl/elevator_dispatcher_if.sv | 32 +++
 rtl/elevator_dispatcher_scan_target_select.sv | 70 +++++++
 rtl/elevator_dispatcher.sv | 133 +++++++++++++
 tb/tb_elevator_dispatcher.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/elevator_pkg.sv
// Purpose: shared floor/state encodings and default timeouts for the elevator dispatcher.
// Latency: n/a (types, constants and one helper only).
// Backpressure: n/a.
package elevator_pkg;

    localparam int NUM_FLOORS = 4;
    localparam int FLOOR_W    = 2;

    localparam int ACK_TIMEOUT_DEF  = 15;
    localparam int TRIP_TIMEOUT_DEF = 31;

    typedef enum logic [FLOOR_W-1:0] {
        FLOOR_G = 2'd0,
        FLOOR_1 = 2'd1,
        FLOOR_2 = 2'd2,
        FLOOR_3 = 2'd3
    } floor_e;

    typedef enum logic [1:0] {
        D_IDLE     = 2'd0,
        D_SELECT   = 2'd1,
        D_DISPATCH = 2'd2,
        D_WAIT     = 2'd3
    } disp_state_e;

    // One-hot mask for a floor index.
    function automatic logic [NUM_FLOORS-1:0] floor_onehot(input logic [FLOOR_W-1:0] f);
        return {{(NUM_FLOORS-1){1'b0}}, 1'b1} << f;
    endfunction

endpackage

// File: rtl/elevator_dispatcher_if.sv
// Purpose: bundles call inputs, car status/command and dispatcher status for one car.
// Latency: n/a (wires only).
// Backpressure: the car acknowledges move_enable by raising elevator_busy.
// master = dispatcher side (drives car commands/status); slave = call logic + car side.
interface elevator_dispatcher_if;
    import elevator_pkg::*;

    logic [NUM_FLOORS-1:0] call_req;
    logic [FLOOR_W-1:0]    current_floor;
    logic                  door_open;
    logic                  elevator_busy;
    logic [FLOOR_W-1:0]    target_floor;
    logic                  move_enable;
    logic [NUM_FLOORS-1:0] pending_calls;
    logic                  dir_up;
    logic                  served_valid;
    logic [FLOOR_W-1:0]    served_floor;
    logic                  fault;

    modport master (
        input  call_req, current_floor, door_open, elevator_busy,
        output target_floor, move_enable, pending_calls, dir_up,
               served_valid, served_floor, fault
    );

    modport slave (
        output call_req, current_floor, door_open, elevator_busy,
        input  target_floor, move_enable, pending_calls, dir_up,
               served_valid, served_floor, fault
    );

endinterface

// File: rtl/elevator_dispatcher_scan_target_select.sv
// Purpose: SCAN next-target pick from pending calls, car position and direction preference.
// Latency: combinational.
// Backpressure: none.
// Ports: pending/current_floor/dir_up in; target_valid/target/next_dir_up out.
module scan_target_select
    import elevator_pkg::*;
(
    input  logic [NUM_FLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0]    current_floor,
    input  logic                  dir_up,
    output logic                  target_valid,
    output logic [FLOOR_W-1:0]    target,
    output logic                  next_dir_up
);

    logic [NUM_FLOORS-1:0] cand;
    logic                  above_vld;
    logic                  below_vld;
    logic [FLOOR_W-1:0]    above_flr;
    logic [FLOOR_W-1:0]    below_flr;

    always_comb begin
        // The car's own floor is never a travel target.
        cand      = pending & ~floor_onehot(current_floor);
        above_vld = 1'b0;
        below_vld = 1'b0;
        above_flr = '0;
        below_flr = '0;
        // Walk downward so the last hit is the nearest floor above.
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (cand[i] && (i > int'(current_floor))) begin
                above_vld = 1'b1;
                above_flr = FLOOR_W'(i);
            end
        end
        // Walk upward so the last hit is the nearest floor below.
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (cand[i] && (i < int'(current_floor))) begin
                below_vld = 1'b1;
                below_flr = FLOOR_W'(i);
            end
        end
    end

    always_comb begin
        target_valid = 1'b0;
        target       = '0;
        next_dir_up  = dir_up;
        if (dir_up) begin
            if (above_vld) begin
                target_valid = 1'b1;
                target       = above_flr;
            end else if (below_vld) begin
                target_valid = 1'b1;
                target       = below_flr;
                next_dir_up  = 1'b0;
            end
        end else begin
            if (below_vld) begin
                target_valid = 1'b1;
                target       = below_flr;
            end else if (above_vld) begin
                target_valid = 1'b1;
                target       = above_flr;
                next_dir_up  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/elevator_dispatcher.sv
// Purpose: per-car call latch + SCAN dispatcher driving target_floor/move_enable of one car.
// Latency: call_req cycle N -> pending N+1 -> select N+2 -> move_enable from N+3.
// Backpressure: move_enable held until elevator_busy rises; ack/trip timeouts set sticky fault.
// Ports: clk, rst (sync, active high), bus (master modport: calls/car status in, commands/status out).
module elevator_dispatcher
    import elevator_pkg::*;
#(
    parameter int ACK_TIMEOUT  = ACK_TIMEOUT_DEF,
    parameter int TRIP_TIMEOUT = TRIP_TIMEOUT_DEF
)
(
    input  logic                  clk,
    input  logic                  rst,
    elevator_dispatcher_if.master bus
);

    // One shared timer covers both timeouts; it restarts on every state change.
    localparam int TMR_MAX = (TRIP_TIMEOUT > ACK_TIMEOUT) ? TRIP_TIMEOUT : ACK_TIMEOUT;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    disp_state_e           state, state_next;
    logic [NUM_FLOORS-1:0] pending_q, pending_next;
    logic [FLOOR_W-1:0]    target_q;
    logic                  move_q;
    logic                  dir_q;
    logic                  served_vld_q;
    logic [FLOOR_W-1:0]    served_flr_q;
    logic                  fault_q;
    logic [TMR_W-1:0]      tmr;
    logic                  fault_set;
    logic                  served_hit;

    logic                  sel_valid;
    logic [FLOOR_W-1:0]    sel_target;
    logic                  sel_dir_up;

    scan_target_select u_sel (
        .pending      (pending_q),
        .current_floor(bus.current_floor),
        .dir_up       (dir_q),
        .target_valid (sel_valid),
        .target       (sel_target),
        .next_dir_up  (sel_dir_up)
    );

    // Clear beats set: a call for the floor whose door is open is served immediately.
    always_comb begin
        pending_next = pending_q | bus.call_req;
        served_hit   = bus.door_open &&
                       (pending_q[bus.current_floor] || bus.call_req[bus.current_floor]);
        if (bus.door_open) begin
            pending_next[bus.current_floor] = 1'b0;
        end
    end

    always_comb begin
        state_next = state;
        fault_set  = 1'b0;
        case (state)
            D_IDLE: begin
                if (sel_valid) begin
                    state_next = D_SELECT;
                end
            end
            D_SELECT: begin
                state_next = sel_valid ? D_DISPATCH : D_IDLE;
            end
            D_DISPATCH: begin
                if (bus.elevator_busy) begin
                    state_next = D_WAIT;
                end else if (tmr == TMR_W'(ACK_TIMEOUT - 1)) begin
                    fault_set  = 1'b1;
                    state_next = D_IDLE;
                end
            end
            D_WAIT: begin
                // Busy falling at any stop sends us back to re-evaluate SCAN order.
                if (!bus.elevator_busy) begin
                    state_next = D_SELECT;
                end else if (tmr == TMR_W'(TRIP_TIMEOUT - 1)) begin
                    fault_set  = 1'b1;
                    state_next = D_IDLE;
                end
            end
            default: state_next = D_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= D_IDLE;
            pending_q    <= '0;
            target_q     <= FLOOR_G;
            move_q       <= 1'b0;
            dir_q        <= 1'b1;
            served_vld_q <= 1'b0;
            served_flr_q <= FLOOR_G;
            fault_q      <= 1'b0;
            tmr          <= '0;
        end else begin
            state        <= state_next;
            pending_q    <= pending_next;
            move_q       <= (state_next == D_DISPATCH);
            served_vld_q <= served_hit;
            if (served_hit) begin
                served_flr_q <= bus.current_floor;
            end
            if (fault_set) begin
                fault_q <= 1'b1;
            end
            if (state == D_SELECT) begin
                dir_q <= sel_dir_up;
                if (sel_valid) begin
                    target_q <= sel_target;
                end
            end
            if (state_next != state) begin
                tmr <= '0;
            end else if (tmr != TMR_W'(TMR_MAX)) begin
                tmr <= tmr + 1'b1;
            end
        end
    end

    assign bus.target_floor  = target_q;
    assign bus.move_enable   = move_q;
    assign bus.pending_calls = pending_q;
    assign bus.dir_up        = dir_q;
    assign bus.served_valid  = served_vld_q;
    assign bus.served_floor  = served_flr_q;
    assign bus.fault         = fault_q;

endmodule

// File: tb/tb_elevator_dispatcher.sv
// Purpose: directed self-checking bench for elevator_dispatcher with a hand-driven car.
// Latency: n/a.
// Backpressure: the bench plays the car, acknowledging move_enable with elevator_busy.
module tb_elevator_dispatcher;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    elevator_dispatcher_if bus();

    elevator_dispatcher #(.ACK_TIMEOUT(15), .TRIP_TIMEOUT(31)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Advance one edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic car(input logic [1:0] f, input logic door, input logic busy);
        bus.current_floor = f;
        bus.door_open     = door;
        bus.elevator_busy = busy;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.call_req = 4'b0000;
        car(2'd0, 1'b0, 1'b0);
        step();
        step();
        checks++; if (bus.pending_calls !== 4'b0000) begin errors++; $display("FAIL reset_pending: got %b exp 0000", bus.pending_calls); end
        checks++; if (bus.move_enable !== 1'b0) begin errors++; $display("FAIL reset_move: got %b exp 0", bus.move_enable); end
        checks++; if (bus.target_floor !== 2'd0) begin errors++; $display("FAIL reset_target: got %0d exp 0", bus.target_floor); end
        checks++; if (bus.dir_up !== 1'b1) begin errors++; $display("FAIL reset_dir: got %b exp 1", bus.dir_up); end
        checks++; if (bus.served_valid !== 1'b0 || bus.served_floor !== 2'd0) begin errors++; $display("FAIL reset_served: got %b/%0d exp 0/0", bus.served_valid, bus.served_floor); end
        checks++; if (bus.fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b exp 0", bus.fault); end
        rst = 1'b0;
    endtask

    task automatic test_single_call();
        car(2'd0, 1'b1, 1'b0);
        bus.call_req = 4'b1000;
        step();
        bus.call_req = 4'b0000;
        checks++; if (bus.pending_calls !== 4'b1000) begin errors++; $display("FAIL single_pending: got %b exp 1000", bus.pending_calls); end
        checks++; if (bus.move_enable !== 1'b0) begin errors++; $display("FAIL single_early_move: got %b exp 0", bus.move_enable); end
        step();
        checks++; if (bus.move_enable !== 1'b0) begin errors++; $display("FAIL single_select_move: got %b exp 0", bus.move_enable); end
        step();
        checks++; if (bus.move_enable !== 1'b1 || bus.target_floor !== 2'd3 || bus.dir_up !== 1'b1) begin errors++; $display("FAIL single_dispatch: got me=%b tgt=%0d dir=%b exp me=1 tgt=3 dir=1", bus.move_enable, bus.target_floor, bus.dir_up); end
        car(2'd0, 1'b0, 1'b1);
        step();
        checks++; if (bus.move_enable !== 1'b0) begin errors++; $display("FAIL single_ack_drop: got %b exp 0", bus.move_enable); end
        car(2'd3, 1'b1, 1'b1);
        step();
        checks++; if (bus.served_valid !== 1'b1 || bus.served_floor !== 2'd3 || bus.pending_calls !== 4'b0000) begin errors++; $display("FAIL single_served: got v=%b f=%0d p=%b exp v=1 f=3 p=0000", bus.served_valid, bus.served_floor, bus.pending_calls); end
        car(2'd3, 1'b1, 1'b0);
        step();
        checks++; if (bus.served_valid !== 1'b0) begin errors++; $display("FAIL single_served_pulse: got %b exp 0", bus.served_valid); end
        step();
        checks++; if (bus.move_enable !== 1'b0) begin errors++; $display("FAIL single_idle: got %b exp 0", bus.move_enable); end
    endtask

    task automatic test_scan_down();
        car(2'd2, 1'b0, 1'b0);
        bus.call_req = 4'b0110;
        step();
        bus.call_req = 4'b0000;
        checks++; if (bus.pending_calls !== 4'b0110) begin errors++; $display("FAIL down_pending: got %b exp 0110", bus.pending_calls); end
        step();
        step();
        checks++; if (bus.move_enable !== 1'b1 || bus.target_floor !== 2'd1 || bus.dir_up !== 1'b0) begin errors++; $display("FAIL down_dispatch: got me=%b tgt=%0d dir=%b exp me=1 tgt=1 dir=0", bus.move_enable, bus.target_floor, bus.dir_up); end
        car(2'd2, 1'b0, 1'b1);
        step();
        car(2'd1, 1'b1, 1'b1);
        step();
        checks++; if (bus.served_valid !== 1'b1 || bus.served_floor !== 2'd1 || bus.pending_calls !== 4'b0100) begin errors++; $display("FAIL down_served: got v=%b f=%0d p=%b exp v=1 f=1 p=0100", bus.served_valid, bus.served_floor, bus.pending_calls); end
        car(2'd1, 1'b0, 1'b0);
        step();
        step();
        checks++; if (bus.move_enable !== 1'b1 || bus.target_floor !== 2'd2 || bus.dir_up !== 1'b1) begin errors++; $display("FAIL down_reverse: got me=%b tgt=%0d dir=%b exp me=1 tgt=2 dir=1", bus.move_enable, bus.target_floor, bus.dir_up); end
        car(2'd1, 1'b0, 1'b1);
        step();
        car(2'd2, 1'b1, 1'b1);
        step();
        car(2'd2, 1'b0, 1'b0);
        step();
        step();
        checks++; if (bus.pending_calls !== 4'b0000 || bus.move_enable !== 1'b0) begin errors++; $display("FAIL down_drain: got p=%b me=%b exp p=0000 me=0", bus.pending_calls, bus.move_enable); end
    endtask

    task automatic test_scan_up_first();
        car(2'd1, 1'b0, 1'b0);
        bus.call_req = 4'b1001;
        step();
        bus.call_req = 4'b0000;
        step();
        step();
        checks++; if (bus.move_enable !== 1'b1 || bus.target_floor !== 2'd3 || bus.dir_up !== 1'b1) begin errors++; $display("FAIL up_first: got me=%b tgt=%0d dir=%b exp me=1 tgt=3 dir=1", bus.move_enable, bus.target_floor, bus.dir_up); end
        car(2'd1, 1'b0, 1'b1);
        step();
        car(2'd3, 1'b1, 1'b1);
        step();
        checks++; if (bus.pending_calls !== 4'b0001 || bus.served_floor !== 2'd3) begin errors++; $display("FAIL up_served: got p=%b f=%0d exp p=0001 f=3", bus.pending_calls, bus.served_floor); end
        car(2'd3, 1'b0, 1'b0);
        step();
        step();
        checks++; if (bus.move_enable !== 1'b1 || bus.target_floor !== 2'd0 || bus.dir_up !== 1'b0) begin errors++; $display("FAIL up_then_down: got me=%b tgt=%0d dir=%b exp me=1 tgt=0 dir=0", bus.move_enable, bus.target_floor, bus.dir_up); end
        car(2'd3, 1'b0, 1'b1);
        step();
        car(2'd0, 1'b1, 1'b1);
        step();
        car(2'd0, 1'b0, 1'b0);
        step();
        step();
    endtask

    task automatic test_call_at_open_door();
        car(2'd1, 1'b1, 1'b0);
        bus.call_req = 4'b0010;
        step();
        bus.call_req = 4'b0000;
        checks++; if (bus.pending_calls !== 4'b0000) begin errors++; $display("FAIL door_pending: got %b exp 0000", bus.pending_calls); end
        checks++; if (bus.served_valid !== 1'b1 || bus.served_floor !== 2'd1) begin errors++; $display("FAIL door_served: got v=%b f=%0d exp v=1 f=1", bus.served_valid, bus.served_floor); end
        step();
        checks++; if (bus.served_valid !== 1'b0) begin errors++; $display("FAIL door_pulse: got %b exp 0", bus.served_valid); end
        step();
        step();
        checks++; if (bus.move_enable !== 1'b0) begin errors++; $display("FAIL door_no_dispatch: got %b exp 0", bus.move_enable); end
    endtask

    task automatic test_ack_timeout();
        car(2'd0, 1'b0, 1'b0);
        bus.call_req = 4'b0100;
        step();
        bus.call_req = 4'b0000;
        step();
        step();
        checks++; if (bus.move_enable !== 1'b1 || bus.fault !== 1'b0) begin errors++; $display("FAIL ack_start: got me=%b fault=%b exp me=1 fault=0", bus.move_enable, bus.fault); end
        repeat (14) step();
        checks++; if (bus.move_enable !== 1'b1 || bus.fault !== 1'b0) begin errors++; $display("FAIL ack_hold: got me=%b fault=%b exp me=1 fault=0", bus.move_enable, bus.fault); end
        step();
        checks++; if (bus.move_enable !== 1'b0 || bus.fault !== 1'b1) begin errors++; $display("FAIL ack_timeout: got me=%b fault=%b exp me=0 fault=1", bus.move_enable, bus.fault); end
        repeat (4) step();
        checks++; if (bus.fault !== 1'b1) begin errors++; $display("FAIL ack_sticky: got %b exp 1", bus.fault); end
    endtask

    task automatic test_rst_mid_trip();
        rst = 1'b1;
        car(2'd0, 1'b0, 1'b0);
        step();
        rst = 1'b0;
        checks++; if (bus.fault !== 1'b0) begin errors++; $display("FAIL rst_fault_clear: got %b exp 0", bus.fault); end
        bus.call_req = 4'b1110;
        step();
        bus.call_req = 4'b0000;
        step();
        step();
        checks++; if (bus.move_enable !== 1'b1 || bus.target_floor !== 2'd1) begin errors++; $display("FAIL rst_dispatch: got me=%b tgt=%0d exp me=1 tgt=1", bus.move_enable, bus.target_floor); end
        car(2'd0, 1'b0, 1'b1);
        step();
        checks++; if (bus.move_enable !== 1'b0 || bus.pending_calls !== 4'b1110) begin errors++; $display("FAIL rst_wait: got me=%b p=%b exp me=0 p=1110", bus.move_enable, bus.pending_calls); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (bus.pending_calls !== 4'b0000 || bus.move_enable !== 1'b0) begin errors++; $display("FAIL rst_clear: got p=%b me=%b exp p=0000 me=0", bus.pending_calls, bus.move_enable); end
        checks++; if (bus.dir_up !== 1'b1 || bus.target_floor !== 2'd0) begin errors++; $display("FAIL rst_dir_target: got dir=%b tgt=%0d exp dir=1 tgt=0", bus.dir_up, bus.target_floor); end
        car(2'd0, 1'b0, 1'b0);
        step();
        step();
        step();
        checks++; if (bus.move_enable !== 1'b0) begin errors++; $display("FAIL rst_idle: got %b exp 0", bus.move_enable); end
    endtask

    task automatic test_trip_timeout();
        car(2'd0, 1'b0, 1'b0);
        bus.call_req = 4'b0010;
        step();
        bus.call_req = 4'b0000;
        step();
        step();
        car(2'd0, 1'b0, 1'b1);
        step();
        checks++; if (bus.move_enable !== 1'b0 || bus.fault !== 1'b0) begin errors++; $display("FAIL trip_wait: got me=%b fault=%b exp me=0 fault=0", bus.move_enable, bus.fault); end
        repeat (30) step();
        checks++; if (bus.fault !== 1'b0) begin errors++; $display("FAIL trip_early: got %b exp 0", bus.fault); end
        step();
        checks++; if (bus.fault !== 1'b1) begin errors++; $display("FAIL trip_timeout: got %b exp 1", bus.fault); end
        car(2'd0, 1'b0, 1'b0);
        step();
    endtask

    initial begin
        bus.call_req      = 4'b0000;
        bus.current_floor = 2'd0;
        bus.door_open     = 1'b0;
        bus.elevator_busy = 1'b0;
        test_reset();
        test_single_call();
        test_scan_down();
        test_scan_up_first();
        test_call_at_open_door();
        test_ack_timeout();
        test_rst_mid_trip();
        test_trip_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
